// File: rtl/result_drain_ctrl.sv
// Result SRAM drain: reads num_rows rows starting at base_addr and streams each row as BEATS OUT_BW-bit beats, lane 0 first.
// Build option RESULT_RELU_EN: lanes with the sign bit set are zeroed at capture; latency is unchanged.
module result_drain_ctrl #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 32,
    parameter int OUT_BW         = 96
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [ADDRESSSIZE-1:0]                base_addr,
    input  logic [ADDRESSSIZE-1:0]                num_rows,
    output logic [ADDRESSSIZE-1:0]                sram_rd_addr,
    input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] sram_rd_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_BW-1:0]                     out_data,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done
);

    localparam int W     = MATRIX_SIZE * PARTIAL_SUM_BW;
    localparam int BEATS = W / OUT_BW;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [ADDRESSSIZE-1:0] r_sram_rd_addr;
    logic [ADDRESSSIZE-1:0] r_rows_left;
    logic [BCW-1:0]         r_beat_cnt;
    logic [W-1:0]           r_shift;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_busy;
    logic                   r_done;

    logic [W-1:0]           w_cap_data;
    logic                   w_accept;
    logic                   w_last_row;
    logic [BCW-1:0]         w_next_beat;

`ifdef RESULT_RELU_EN
    always_comb begin
        w_cap_data = sram_rd_data;
        for (int l = 0; l < MATRIX_SIZE; l++) begin
            if (sram_rd_data[l*PARTIAL_SUM_BW + PARTIAL_SUM_BW - 1]) begin
                w_cap_data[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
            end
        end
    end
`else
    assign w_cap_data = sram_rd_data;
`endif

    assign w_accept    = r_out_valid && out_ready;
    assign w_last_row  = (r_rows_left == ADDRESSSIZE'(1));
    assign w_next_beat = r_beat_cnt + BCW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_sram_rd_addr <= '0;
            r_rows_left    <= '0;
            r_beat_cnt     <= '0;
            r_shift        <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else if (abort) begin
            // Abort wins over start and over a beat handshaking in the same cycle.
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (num_rows == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state        <= S_RD;
                            r_rows_left    <= num_rows;
                            r_sram_rd_addr <= base_addr;
                            r_beat_cnt     <= '0;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_state     <= S_STREAM;
                    r_shift     <= w_cap_data;
                    r_beat_cnt  <= '0;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last_row && (BEATS == 1);
                end
                S_STREAM: begin
                    if (w_accept) begin
                        r_shift <= r_shift >> OUT_BW;
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_beat_cnt  <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (w_last_row) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state        <= S_RD;
                                r_rows_left    <= r_rows_left - ADDRESSSIZE'(1);
                                r_sram_rd_addr <= r_sram_rd_addr + ADDRESSSIZE'(1);
                            end
                        end else begin
                            r_beat_cnt <= w_next_beat;
                            r_out_last <= w_last_row && (w_next_beat == LAST_BEAT);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sram_rd_addr = r_sram_rd_addr;
    assign out_valid    = r_out_valid;
    assign out_data     = r_shift[OUT_BW-1:0];
    assign out_last     = r_out_last;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Directed bench for result_drain_ctrl: table of drain scenarios plus abort and mid-stream reset sequences.
module tb_result_drain_ctrl;
    localparam int AW    = 10;
    localparam int LB    = 24;
    localparam int NL    = 32;
    localparam int OBW   = 96;
    localparam int W     = NL * LB;
    localparam int BEATS = W / OBW;
    localparam int LPB   = OBW / LB;

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           out_ready = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [AW-1:0]  num_rows = '0;
    logic [AW-1:0]  sram_rd_addr;
    logic [W-1:0]   sram_rd_data = '0;
    logic           out_valid;
    logic           out_last;
    logic           busy;
    logic           done;
    logic [OBW-1:0] out_data;

    int sram_mode = 0;
    int n_vec = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] nrows;
        bit            toggle;
        int            mode;
        bit            poke;
        int            exp_beats;
        int            exp_first;
        int            exp_done;
    } vec_t;

    vec_t tbl[6];

    result_drain_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Row content: lane j of row a is 24*a+j; mode 1 makes even lanes all-ones (negative).
    function automatic logic [W-1:0] make_row(input logic [AW-1:0] addr, input int mode);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < NL; j++) begin
            if (mode == 1 && j % 2 == 0) r[j*LB +: LB] = 24'hFFFFFF;
            else                         r[j*LB +: LB] = 24'(24 * int'(addr) + j);
        end
        return r;
    endfunction

    function automatic logic [LB-1:0] exp_lane(input logic [AW-1:0] addr, input int j, input int mode);
        if (mode == 1 && j % 2 == 0) begin
`ifdef RESULT_RELU_EN
            return 24'h000000;
`else
            return 24'hFFFFFF;
`endif
        end
        return 24'(24 * int'(addr) + j);
    endfunction

    function automatic logic [OBW-1:0] exp_beat(input logic [AW-1:0] addr, input int k, input int mode);
        logic [OBW-1:0] b;
        b = '0;
        for (int m = 0; m < LPB; m++) b[m*LB +: LB] = exp_lane(addr, k * LPB + m, mode);
        return b;
    endfunction

    always @(posedge clk) sram_rd_data <= make_row(sram_rd_addr, sram_mode);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle 0 is the negedge where start is raised; cycle k is observed after the k-th following posedge.
    task automatic run_drain(input vec_t v);
        int             nb;
        int             first_valid;
        int             done_cyc;
        int             gap;
        int             total;
        logic           prev_held;
        logic           prev_last;
        logic [OBW-1:0] prev_data;
        logic [AW-1:0]  addr_before;
        nb = 0; first_valid = -1; done_cyc = -1; gap = 0;
        prev_held = 1'b0; prev_last = 1'b0; prev_data = '0;
        total = int'(v.nrows) * BEATS;
        sram_mode = v.mode;
        @(negedge clk);
        addr_before = sram_rd_addr;
        base_addr = v.base; num_rows = v.nrows; start = 1'b1; out_ready = !v.toggle;
        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = (v.poke && cyc == 5);
            if (start) begin
                base_addr = AW'(3);
                num_rows  = AW'(9);
            end
            out_ready = v.toggle ? (cyc % 2 == 1) : 1'b1;
            if (cyc == 1) begin
                chk("busy_after_start", busy, 1'b1);
                if (v.nrows != '0) chk("rd_addr_first", sram_rd_addr, v.base);
            end
            if (prev_held) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (gap > 0) begin
                    chk("row_gap", gap, 2);
                    gap = 0;
                end
                if (out_ready) begin
                    if (nb < total) begin
                        chk($sformatf("beat%0d_data", nb), out_data,
                            exp_beat(AW'(v.base + AW'(nb / BEATS)), nb % BEATS, v.mode));
                        chk($sformatf("beat%0d_last", nb), out_last, nb == total - 1);
                    end
                    nb++;
                end
            end else if (first_valid >= 0) begin
                gap++;
            end
            prev_held = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (done) begin
                done_cyc = cyc;
                chk("done_with_last", out_last, 1'b0);
                chk("busy_in_done", busy, 1'b1);
            end
        end
        chk("beat_count", nb, v.exp_beats);
        chk("first_valid_cycle", first_valid, v.exp_first);
        chk("done_cycle", done_cyc, v.exp_done);
        if (v.nrows == '0) chk("no_read_addr", sram_rd_addr, addr_before);
        else               chk("rd_addr_final", sram_rd_addr, AW'(v.base + v.nrows - AW'(1)));
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
        chk("done_single_pulse", done, 1'b0);
    endtask

    initial begin
        logic seen;
        tbl[0] = '{base: 10'd0,    nrows: 10'd2, toggle: 1'b0, mode: 0, poke: 1'b0, exp_beats: 16, exp_first: 3,  exp_done: 21};
        tbl[1] = '{base: 10'd0,    nrows: 10'd2, toggle: 1'b1, mode: 0, poke: 1'b0, exp_beats: 16, exp_first: 3,  exp_done: 36};
        tbl[2] = '{base: 10'd5,    nrows: 10'd0, toggle: 1'b0, mode: 0, poke: 1'b0, exp_beats: 0,  exp_first: -1, exp_done: 1};
        tbl[3] = '{base: 10'd1023, nrows: 10'd2, toggle: 1'b0, mode: 0, poke: 1'b1, exp_beats: 16, exp_first: 3,  exp_done: 21};
        tbl[4] = '{base: 10'd7,    nrows: 10'd1, toggle: 1'b0, mode: 1, poke: 1'b0, exp_beats: 8,  exp_first: 3,  exp_done: 11};
        tbl[5] = '{base: 10'd100,  nrows: 10'd3, toggle: 1'b0, mode: 0, poke: 1'b0, exp_beats: 24, exp_first: 3,  exp_done: 31};

        #1 rstn = 1'b0;
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", sram_rd_addr, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) run_drain(tbl[i]);

        // Abort raised while beat 3 of row 0 is handshaking.
        @(negedge clk);
        sram_mode = 0; base_addr = '0; num_rows = AW'(2); start = 1'b1; out_ready = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_pre_valid", out_valid, 1'b1);
        chk("abort_pre_data", out_data, exp_beat(AW'(0), 3, 0));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | done | out_valid | busy;
        end
        chk("abort_quiet", seen, 1'b0);

        // Reset asserted mid-stream clears outputs immediately; a fresh start then drains normally.
        @(negedge clk);
        base_addr = AW'(9); num_rows = AW'(2); start = 1'b1; out_ready = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("prereset_valid", out_valid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_data", out_data, '0);
        chk("midrst_last", out_last, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_addr", sram_rd_addr, '0);
        @(negedge clk);
        rstn = 1'b1;
        run_drain(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
